// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit and its HI/LO registers.
package muldiv_pkg;

  // Operation encodings, identical to the ALU alu_control field.
  localparam logic [4:0] OP_MULT  = 5'b01010;
  localparam logic [4:0] OP_MULTU = 5'b01011;
  localparam logic [4:0] OP_DIV   = 5'b01100;
  localparam logic [4:0] OP_DIVU  = 5'b01101;
  localparam logic [4:0] OP_MTLO  = 5'b01111;
  localparam logic [4:0] OP_MTHI  = 5'b10000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter_datapath.sv
// Iterative datapath: radix-2 shift-add multiply and restoring divide on operand
// magnitudes, with the sign fix applied combinationally on the result outputs.
module muldiv_iter_datapath
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic               is_div;
  logic               neg_prod;
  logic               neg_quo;
  logic               neg_rem;

  logic               sgn;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic [WIDTH:0]     rem_sh;
  logic               take;
  logic [WIDTH-1:0]   rem_new;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [2*WIDTH-1:0] div_nxt;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Operand magnitudes; 0x80000000 negates to itself, which is the correct unsigned magnitude.
  always_comb begin
    sgn   = (op == OP_MULT) || (op == OP_DIV);
    a_neg = sgn && a[WIDTH-1];
    b_neg = sgn && b[WIDTH-1];
    a_mag = a_neg ? (~a + WIDTH'(1)) : a;
    b_mag = b_neg ? (~b + WIDTH'(1)) : b;
  end

  // One iteration of each algorithm; opb holds the multiplier (MSB first) or the divisor.
  always_comb begin
    rem_sh  = {acc[2*WIDTH-1:WIDTH], opa[WIDTH-1]};
    take    = (rem_sh >= {1'b0, opb});
    rem_new = take ? (rem_sh[WIDTH-1:0] - opb) : rem_sh[WIDTH-1:0];
    div_nxt = {rem_new, acc[WIDTH-2:0], take};
    mul_nxt = {acc[2*WIDTH-2:0], 1'b0} + (opb[WIDTH-1] ? {{WIDTH{1'b0}}, opa} : '0);
  end

  // Operand capture on load, then one shift/add or shift/subtract per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      opa      <= '0;
      opb      <= '0;
      is_div   <= 1'b0;
      neg_prod <= 1'b0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
    end else if (load) begin
      acc      <= '0;
      opa      <= a_mag;
      opb      <= b_mag;
      is_div   <= (op == OP_DIV) || (op == OP_DIVU);
      neg_prod <= a_neg ^ b_neg;
      // A zero divisor leaves an all-ones quotient that must not be negated.
      neg_quo  <= (a_neg ^ b_neg) && (|b);
      neg_rem  <= a_neg;
    end else if (step) begin
      if (is_div) begin
        acc <= div_nxt;
        opa <= {opa[WIDTH-2:0], 1'b0};
      end else begin
        acc <= mul_nxt;
        opb <= {opb[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign fix and HI/LO selection for the writeback cycle.
  always_comb begin
    prod_fix = neg_prod ? (~acc + (2*WIDTH)'(1)) : acc;
    quo_fix  = neg_quo ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + WIDTH'(1)) : acc[2*WIDTH-1:WIDTH];
    res_hi   = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = is_div ? quo_fix : prod_fix[WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the architectural HI/LO registers.
//
// state | meaning
// IDLE  | accepts start; MTHI/MTLO written here, mul/div operands latched
// CALC  | one iteration per cycle, counter 0..WIDTH-1
// FIX   | sign-fixed result written to HI/LO, done pulsed, back to IDLE
module muldiv_hilo_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             step;
  logic             wb;
  logic             mtlo_we;
  logic             mthi_we;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  muldiv_iter_datapath #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .step   (step),
    .op     (op),
    .a      (A),
    .b      (B),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  // Next-state and control decode; abort beats both a new start and the FIX writeback.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    wb        = 1'b0;
    mtlo_we   = 1'b0;
    mthi_we   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (is_muldiv(op)) begin
            load      = 1'b1;
            state_nxt = CALC;
          end else if (op == OP_MTLO) begin
            mtlo_we = 1'b1;
          end else if (op == OP_MTHI) begin
            mthi_we = 1'b1;
          end
        end
      end
      CALC: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          step = 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
        end
      end
      FIX: begin
        state_nxt = IDLE;
        wb        = !abort;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, iteration counter, HI/LO and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      HI    <= '0;
      LO    <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= wb;
      if (load) cnt <= '0;
      else if (step) cnt <= cnt + CNT_W'(1);
      if (wb) begin
        HI <= res_hi;
        LO <= res_lo;
      end
      if (mtlo_we) LO <= B;
      if (mthi_we) HI <= B;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Scoreboard bench: stimulus pushes expected HI/LO, a monitor checks them on each done pulse.
module tb_muldiv_hilo_ctrl;
  import muldiv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        abort;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  muldiv_hilo_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected done=0 at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk({e.name, "_hi"}, HI, e.hi);
          chk({e.name, "_lo"}, LO, e.lo);
        end
      end
    end
  end

  task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [4:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int cyc;
    exp_q.push_back('{name, eh, el});
    issue(o, a, b);
    cyc = 0;
    @(negedge clk);
    while (busy && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    chk({name, "_busy_cycles"}, 32'(cyc), 32'd33);
    chk({name, "_done"}, {31'b0, done}, 32'd1);
    @(negedge clk);
    chk({name, "_done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 5'd0;
    A     = '0;
    B     = '0;
    abort = 1'b0;
    #1;
    chk("reset_hi", HI, 32'h0);
    chk("reset_lo", LO, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("mult",      OP_MULT,  32'h86E1FB43, 32'h6B72C901, 32'hCD2A258D, 32'hD9FF9643);
    run_op("multu",     OP_MULTU, 32'h86E1FB43, 32'h6B72C901, 32'h389CEE8E, 32'hD9FF9643);
    run_op("multu2",    OP_MULTU, 32'h73A219F6, 32'h48C1B302, 32'h20DD155E, 32'h01E135EC);
    run_op("div",       OP_DIV,   32'h8396A10C, 32'h02A13C92, 32'hFF30BFDA, 32'hFFFFFFD1);
    run_op("divu",      OP_DIVU,  32'h8396A10C, 32'h02A13C92, 32'h0018CC88, 32'h00000032);

    issue(OP_MTLO, 32'h0, 32'h7B93A612);
    chk("mtlo_lo", LO, 32'h7B93A612);
    chk("mtlo_hi", HI, 32'h0018CC88);
    chk("mtlo_busy", {31'b0, busy}, 32'd0);
    chk("mtlo_done", {31'b0, done}, 32'd0);

    run_op("divu_by0",  OP_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF);
    run_op("div_by0",   OP_DIV,   32'h87654321, 32'h00000000, 32'h87654321, 32'hFFFFFFFF);
    run_op("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("mult_min",  OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);

    // Abort mid-CALC, with an MTHI issued while busy that must be ignored.
    issue(OP_MTHI, 32'h0, 32'h11111111);
    issue(OP_MTLO, 32'h0, 32'h22222222);
    issue(OP_MULT, 32'h86E1FB43, 32'h6B72C901);
    repeat (3) @(negedge clk);
    issue(OP_MTHI, 32'h0, 32'hDEADBEEF);
    repeat (5) @(negedge clk);
    chk("abort_busy_before", {31'b0, busy}, 32'd1);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_hi", HI, 32'h11111111);
    chk("abort_lo", LO, 32'h22222222);
    repeat (40) @(negedge clk);
    chk("abort_hi_later", HI, 32'h11111111);
    chk("abort_lo_later", LO, 32'h22222222);

    // Abort in IDLE suppresses a coincident start.
    @(negedge clk);
    abort = 1'b1;
    issue(OP_MTLO, 32'h0, 32'h55555555);
    abort = 1'b0;
    chk("idle_abort_lo", LO, 32'h22222222);
    chk("idle_abort_busy", {31'b0, busy}, 32'd0);

    // Reset mid-CALC returns everything to reset values at once.
    issue(OP_MULTU, 32'h3, 32'h5);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_hi", HI, 32'h0);
    chk("rst_mid_lo", LO, 32'h0);
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst_mid_idle", {31'b0, busy}, 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
